// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM state encoding, ALU and PC-select codes for the multi-cycle sequencer.
// The control bundle type lets the decoder hand every datapath line to the top as one value.
package cpu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_CMP  = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_BNE  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_CALL = 4'hB;
    localparam logic [3:0] OP_RET  = 4'hC;
    localparam logic [3:0] OP_JR   = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_RETIRE,
        ST_HALT,
        ST_FAULT
    } state_e;

    localparam logic [1:0] FS_ADD = 2'b00;
    localparam logic [1:0] FS_SUB = 2'b01;
    localparam logic [1:0] FS_AND = 2'b10;
    localparam logic [1:0] FS_OR  = 2'b11;

    localparam logic [1:0] PC_RA  = 2'd0;
    localparam logic [1:0] PC_INC = 2'd1;
    localparam logic [1:0] PC_OFS = 2'd2;
    localparam logic [1:0] PC_REG = 2'd3;

    typedef struct packed {
        logic [2:0] r_sel1;
        logic [2:0] r_sel2;
        logic [2:0] wr_sel;
        logic       rf_we;
        logic       rf_re;
        logic       op2_imm;
        logic [1:0] fun_sel;
        logic       wb_alu;
        logic [1:0] pc_sel;
        logic       ld_ra;
        logic       pc_ld;
        logic       dm_re;
        logic       dm_we;
        logic       halted;
        logic       fault;
    } ctrl_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational map from (state, latched instruction, latched flags) to datapath controls.
// Zero latency; no handshake of its own.
module seq_decode
    import cpu_pkg::*;
(
    input  state_e      state,
    input  logic [15:0] ir_q,
    input  logic [3:0]  flag_q,
    output ctrl_t       ctrl
);

    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       flag_z;
    logic       unused_bits;

    assign op          = ir_q[15:12];
    assign rd          = ir_q[11:9];
    assign rs1         = ir_q[8:6];
    assign rs2         = ir_q[5:3];
    assign flag_z      = flag_q[3];
    // Immediate low bits and N/C/V are consumed by the datapath, not here.
    assign unused_bits = ^{ir_q[2:0], flag_q[2:0]};

    always_comb begin
        ctrl        = '0;
        ctrl.pc_sel = PC_INC;

        // Register reads and ALU set-up stay stable from DECODE through WB.
        if (state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
            ctrl.rf_re   = 1'b1;
            ctrl.r_sel1  = (op == OP_ADDI || op == OP_ST || op == OP_JR) ? rd : rs1;
            ctrl.r_sel2  = rs2;
            ctrl.op2_imm = (op == OP_ADDI) || (op == OP_ST);
            case (op)
                OP_SUB, OP_CMP: ctrl.fun_sel = FS_SUB;
                OP_AND:         ctrl.fun_sel = FS_AND;
                OP_OR:          ctrl.fun_sel = FS_OR;
                default:        ctrl.fun_sel = FS_ADD;
            endcase
        end

        case (state)
            ST_EXEC: begin
                case (op)
                    OP_BEQ: begin
                        ctrl.pc_ld  = 1'b1;
                        ctrl.pc_sel = flag_z ? PC_OFS : PC_INC;
                    end
                    OP_BNE: begin
                        ctrl.pc_ld  = 1'b1;
                        ctrl.pc_sel = flag_z ? PC_INC : PC_OFS;
                    end
                    OP_JMP: begin
                        ctrl.pc_ld  = 1'b1;
                        ctrl.pc_sel = PC_OFS;
                    end
                    OP_CALL: begin
                        ctrl.pc_ld  = 1'b1;
                        ctrl.ld_ra  = 1'b1;
                        ctrl.pc_sel = PC_OFS;
                    end
                    OP_RET: begin
                        ctrl.pc_ld  = 1'b1;
                        ctrl.pc_sel = PC_RA;
                    end
                    OP_JR: begin
                        ctrl.pc_ld  = 1'b1;
                        ctrl.pc_sel = PC_REG;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                ctrl.dm_re = (op == OP_LD);
                ctrl.dm_we = (op == OP_ST);
            end
            ST_WB: begin
                ctrl.rf_we  = 1'b1;
                ctrl.wr_sel = rd;
                ctrl.wb_alu = (op != OP_LD);
                ctrl.pc_ld  = 1'b1;
            end
            ST_RETIRE: ctrl.pc_ld  = 1'b1;
            ST_HALT:   ctrl.halted = 1'b1;
            ST_FAULT:  ctrl.fault  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: owns the IR latch, branch flag latch and data-memory timeout.
// MEM waits on dm_ready up to MEM_TIMEOUT cycles, then parks in FAULT until run.
module multicycle_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CW          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic [3:0]  flags,
    input  logic        dm_ready,
    input  logic        run,
    output logic [2:0]  rChooseOne,
    output logic [2:0]  rChooseTwo,
    output logic [2:0]  writeChoose,
    output logic        inOrNot,
    output logic        outOrNot,
    output logic        chooseOperand2,
    output logic [1:0]  funSel,
    output logic        chooseWriteBack,
    output logic [1:0]  choosePCUpdate,
    output logic        ldRA,
    output logic        pc_ld,
    output logic        dm_re,
    output logic        dm_we,
    output logic        halted,
    output logic        fault
);

    localparam logic [CW-1:0] CNT_LIMIT = CW'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [3:0]  flag_q, flag_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [3:0]  op;
    ctrl_t       ctrl;

    assign op      = ir_q[15:12];
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        flag_d  = flag_q;
        cnt_d   = '0;

        case (state_q)
            ST_FETCH: begin
                ir_d    = ir;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (op == OP_HALT)     state_d = ST_HALT;
                else if (op == OP_NOP) state_d = ST_RETIRE;
                else                   state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_alu_op(op)) begin
                    flag_d  = flags;
                    state_d = ST_WB;
                end else if (op == OP_CMP) begin
                    flag_d  = flags;
                    state_d = ST_RETIRE;
                end else if (op == OP_LD || op == OP_ST) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                // dm_ready wins over the timeout when both land on the same cycle.
                if (dm_ready)                  state_d = (op == OP_LD) ? ST_WB : ST_RETIRE;
                else if (cnt_inc == CNT_LIMIT) state_d = ST_FAULT;
                else                           cnt_d   = cnt_inc;
            end
            ST_WB, ST_RETIRE: state_d = ST_FETCH;
            ST_HALT, ST_FAULT: begin
                if (run) state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
            flag_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
        end
    end

    seq_decode u_decode (
        .state  (state_q),
        .ir_q   (ir_q),
        .flag_q (flag_q),
        .ctrl   (ctrl)
    );

    assign rChooseOne      = ctrl.r_sel1;
    assign rChooseTwo      = ctrl.r_sel2;
    assign writeChoose     = ctrl.wr_sel;
    assign inOrNot         = ctrl.rf_we;
    assign outOrNot        = ctrl.rf_re;
    assign chooseOperand2  = ctrl.op2_imm;
    assign funSel          = ctrl.fun_sel;
    assign chooseWriteBack = ctrl.wb_alu;
    assign choosePCUpdate  = ctrl.pc_sel;
    assign ldRA            = ctrl.ld_ra;
    assign pc_ld           = ctrl.pc_ld;
    assign dm_re           = ctrl.dm_re;
    assign dm_we           = ctrl.dm_we;
    assign halted          = ctrl.halted;
    assign fault           = ctrl.fault;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-instruction output traces checked against hand-derived values.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic [3:0]  flags;
    logic        dm_ready;
    logic        run;
    logic [2:0]  rChooseOne, rChooseTwo, writeChoose;
    logic        inOrNot, outOrNot, chooseOperand2, chooseWriteBack;
    logic [1:0]  funSel, choosePCUpdate;
    logic        ldRA, pc_ld, dm_re, dm_we, halted, fault;

    always #5 clk = ~clk;

    multicycle_sequencer #(.MEM_TIMEOUT(16), .CW(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .ir              (ir),
        .flags           (flags),
        .dm_ready        (dm_ready),
        .run             (run),
        .rChooseOne      (rChooseOne),
        .rChooseTwo      (rChooseTwo),
        .writeChoose     (writeChoose),
        .inOrNot         (inOrNot),
        .outOrNot        (outOrNot),
        .chooseOperand2  (chooseOperand2),
        .funSel          (funSel),
        .chooseWriteBack (chooseWriteBack),
        .choosePCUpdate  (choosePCUpdate),
        .ldRA            (ldRA),
        .pc_ld           (pc_ld),
        .dm_re           (dm_re),
        .dm_we           (dm_we),
        .halted          (halted),
        .fault           (fault)
    );

    typedef struct packed {
        logic       pcld;
        logic [1:0] cpu;
        logic       rf_we;
        logic       rf_re;
        logic [2:0] wc;
        logic       op2;
        logic [1:0] fs;
        logic       wb;
        logic       ldra;
        logic       re;
        logic       we;
        logic       hlt;
        logic       flt;
    } snap_t;

    snap_t trace[$];
    int    total   = 0;
    int    bad     = 0;
    int    overlap = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // which: 0 pc_ld, 1 dm_re, 2 dm_we
    function automatic int count(input int which);
        int n = 0;
        foreach (trace[i]) begin
            case (which)
                0:       n += int'(trace[i].pcld);
                1:       n += int'(trace[i].re);
                default: n += int'(trace[i].we);
            endcase
        end
        return n;
    endfunction

    // Starts in FETCH; records one snapshot per cycle until retirement, HALT or FAULT.
    // rdy_wait: number of MEM cycles before dm_ready is raised (-1 = never).
    task automatic run_instr(input logic [15:0] instr, input logic [3:0] flg, input int rdy_wait);
        int    mem_cnt = 0;
        bit    done;
        snap_t s;
        ir    = instr;
        flags = flg;
        trace.delete();
        for (int i = 0; i < 40; i++) begin
            dm_ready = (dm_re || dm_we) && (mem_cnt == rdy_wait);
            s.pcld  = pc_ld;
            s.cpu   = choosePCUpdate;
            s.rf_we = inOrNot;
            s.rf_re = outOrNot;
            s.wc    = writeChoose;
            s.op2   = chooseOperand2;
            s.fs    = funSel;
            s.wb    = chooseWriteBack;
            s.ldra  = ldRA;
            s.re    = dm_re;
            s.we    = dm_we;
            s.hlt   = halted;
            s.flt   = fault;
            trace.push_back(s);
            if (int'(inOrNot) + int'(dm_re) + int'(dm_we) > 1) overlap++;
            if (dm_re || dm_we) mem_cnt++;
            done = pc_ld || halted || fault;
            tick();
            if (done) break;
        end
        dm_ready = 1'b0;
    endtask

    initial begin
        int viol;
        rst = 1'b0; ir = 16'h0; flags = 4'h0; dm_ready = 1'b0; run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_cpu",    choosePCUpdate, 1);
        check("rst_pcld",   pc_ld, 0);
        check("rst_rd_en",  outOrNot, 0);
        check("rst_status", {halted, fault}, 0);
        check("rst_dm",     {dm_re, dm_we, inOrNot}, 0);
        rst = 1'b1;

        // ADDI r1,#-3
        run_instr(16'h42FD, 4'h0, -1);
        check("addi_cycles", trace.size(), 4);
        check("addi_pcld_n", count(0), 1);
        check("addi_dec_re", trace[1].rf_re, 1);
        check("addi_wb_we",  trace[3].rf_we, 1);
        check("addi_wb_wc",  trace[3].wc, 1);
        check("addi_wb_op2", trace[3].op2, 1);
        check("addi_wb_fs",  trace[3].fs, 0);
        check("addi_wb_src", trace[3].wb, 1);
        check("addi_wb_cpu", {trace[3].pcld, trace[3].cpu}, {1'b1, 2'd1});

        // CMP r2,r3 with Z set, then BEQ +8 sees latched Z despite flags input now 0
        run_instr(16'h5098, 4'b1000, -1);
        check("cmp_exec_fs", trace[2].fs, 1);
        check("cmp_pcld_n",  count(0), 1);
        run_instr(16'h8008, 4'b0000, -1);
        check("beq_t_cycles", trace.size(), 3);
        check("beq_t_exec",   {trace[2].pcld, trace[2].cpu}, {1'b1, 2'd2});
        run_instr(16'h5098, 4'b0000, -1);
        run_instr(16'h8008, 4'b1000, -1);
        check("beq_nt_exec",  {trace[2].pcld, trace[2].cpu}, {1'b1, 2'd1});
        run_instr(16'h9008, 4'b1000, -1);
        check("bne_t_exec",   {trace[2].pcld, trace[2].cpu}, {1'b1, 2'd2});

        // LD r4,[r1+r2] with dm_ready on the 4th MEM cycle
        run_instr(16'h6850, 4'h0, 3);
        check("ld_cycles",  trace.size(), 8);
        check("ld_re_n",    count(1), 4);
        check("ld_exec_re", trace[2].re, 0);
        check("ld_wb",      {trace[7].rf_we, trace[7].wb, trace[7].wc}, {1'b1, 1'b0, 3'd4});
        check("ld_pcld_n",  count(0), 1);

        // ST: ready on the 16th MEM cycle still succeeds
        run_instr(16'h7605, 4'h0, 15);
        check("st_lim_cycles", trace.size(), 20);
        check("st_lim_we_n",   count(2), 16);
        check("st_lim_retire", {trace[19].pcld, trace[19].flt}, {1'b1, 1'b0});

        // ST: dm_ready never arrives
        run_instr(16'h7605, 4'h0, -1);
        check("st_to_cycles", trace.size(), 20);
        check("st_to_we_n",   count(2), 16);
        check("st_to_fault",  {trace[19].flt, trace[19].we, trace[19].pcld}, {1'b1, 1'b0, 1'b0});
        tick();
        check("fault_holds",  fault, 1);
        run = 1'b1;
        tick();
        run = 1'b0;
        check("fault_run",    fault, 0);
        run_instr(16'hE000, 4'h0, -1);
        check("nop_cycles",   trace.size(), 3);
        check("nop_pcld",     trace[2].pcld, 1);

        // CALL +20, RET, JR
        run_instr(16'hB014, 4'h0, -1);
        check("call_cycles", trace.size(), 3);
        check("call_exec",   {trace[2].ldra, trace[2].pcld, trace[2].cpu}, {1'b1, 1'b1, 2'd2});
        run_instr(16'hC000, 4'h0, -1);
        check("ret_exec",    {trace[2].ldra, trace[2].pcld, trace[2].cpu}, {1'b0, 1'b1, 2'd0});
        run_instr(16'hD000, 4'h0, -1);
        check("jr_exec",     {trace[2].pcld, trace[2].cpu}, {1'b1, 2'd3});

        // HALT holds with no enables; run is the only way out
        run_instr(16'hF000, 4'h0, -1);
        check("halt_cycles", trace.size(), 3);
        check("halt_flag",   trace[2].hlt, 1);
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            if (!halted || pc_ld || inOrNot || outOrNot || dm_re || dm_we || ldRA) viol++;
            tick();
        end
        check("halt_hold", viol, 0);
        run = 1'b1;
        tick();
        run = 1'b0;
        check("halt_run", halted, 0);

        // Asynchronous reset in the middle of a LD's MEM wait
        ir = 16'h6850;
        tick(); tick(); tick();
        check("ld_mem_re", dm_re, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_dm_re", {dm_re, dm_we, pc_ld}, 0);
        check("arst_cpu",   choosePCUpdate, 1);
        @(negedge clk);
        rst = 1'b1;
        run_instr(16'hE000, 4'h0, -1);
        check("arst_nop", trace.size(), 3);

        check("no_overlap", overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
